// File: rtl/sync_frame_fifo.sv
// sync_frame_fifo
//   Single-clock FIFO that only exposes complete frames to the reader.
//   Words are written speculatively at wr_ptr; a frame becomes readable when
//   its last word is accepted, which moves cm_ptr up to wr_ptr. A frame that
//   hits an overflow is rolled back on its last word and never seen by the
//   reader. w_drop discards the frame in progress.
//
// Ports
//   clk, arst            clock, asynchronous active-high reset
//   w_en, data_in        write request and data
//   w_last               marks the written word as end of frame
//   w_drop               discard the uncommitted frame in progress
//   r_en                 read request
//   clr_err              clear sticky overflow/underflow
//   data_out, r_last     registered read word and its end-of-frame bit
//   r_valid              data_out/r_last valid (one cycle after accepted r_en)
//   full, empty          no free slot (incl. uncommitted) / no committed word
//   afull, aempty        occupancy >= AFULL_TH / level <= AEMPTY_TH
//   level                committed words stored
//   overflow, underflow  sticky error flags
module sync_frame_fifo #(
    parameter int WIDTH     = 8,
    parameter int SIZE      = 16,
    parameter int PTR_LEN   = $clog2(SIZE),
    parameter int AFULL_TH  = SIZE - 2,
    parameter int AEMPTY_TH = 1
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               w_en,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               w_last,
    input  logic               w_drop,
    input  logic               r_en,
    input  logic               clr_err,
    output logic [WIDTH-1:0]   data_out,
    output logic               r_valid,
    output logic               r_last,
    output logic               full,
    output logic               empty,
    output logic               afull,
    output logic               aempty,
    output logic [PTR_LEN:0]   level,
    output logic               overflow,
    output logic               underflow
);

    localparam logic [PTR_LEN:0] PTR_ONE = 1;

    logic [WIDTH:0]   mem [SIZE];

    logic [PTR_LEN:0] wr_ptr, cm_ptr, rd_ptr;
    logic [PTR_LEN:0] wr_ptr_nxt, cm_ptr_nxt;
    logic [PTR_LEN:0] occ;
    logic             ferr, ferr_nxt;

    logic             wr_accept;
    logic             wr_ovf;
    logic             rd_fire;
    logic             rd_unf;

    // Flags come from registered pointers only, so a same-cycle read or
    // commit never changes what this cycle's write/read is allowed to do.
    assign full  = (wr_ptr[PTR_LEN-1:0] == rd_ptr[PTR_LEN-1:0]) &&
                   (wr_ptr[PTR_LEN] != rd_ptr[PTR_LEN]);
    assign empty = (cm_ptr == rd_ptr);

    assign level  = cm_ptr - rd_ptr;
    assign occ    = wr_ptr - rd_ptr;
    assign afull  = (occ >= (PTR_LEN+1)'(AFULL_TH));
    assign aempty = (level <= (PTR_LEN+1)'(AEMPTY_TH));

    assign wr_accept = w_en && !full && !w_drop;
    assign wr_ovf    = w_en && full && !w_drop;
    assign rd_fire   = r_en && !empty;
    assign rd_unf    = r_en && empty;

    // Write-side pointer control. An overflowing last word closes its own
    // broken frame, so the error is seen as pending in the same cycle.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        cm_ptr_nxt = cm_ptr;
        ferr_nxt   = ferr;
        if (w_drop) begin
            // The errored frame (if any) is the one being dropped.
            wr_ptr_nxt = cm_ptr;
            ferr_nxt   = 1'b0;
        end else if (wr_ovf) begin
            if (w_last) begin
                wr_ptr_nxt = cm_ptr;
                ferr_nxt   = 1'b0;
            end else begin
                ferr_nxt   = 1'b1;
            end
        end else if (wr_accept) begin
            if (w_last && ferr) begin
                wr_ptr_nxt = cm_ptr;
                ferr_nxt   = 1'b0;
            end else begin
                wr_ptr_nxt = wr_ptr + PTR_ONE;
                if (w_last)
                    cm_ptr_nxt = wr_ptr + PTR_ONE;
            end
        end else if (w_last && ferr) begin
            wr_ptr_nxt = cm_ptr;
            ferr_nxt   = 1'b0;
        end
    end

    // Storage has no reset; contents are only observable behind cm_ptr.
    always_ff @(posedge clk) begin
        if (wr_accept)
            mem[wr_ptr[PTR_LEN-1:0]] <= {w_last, data_in};
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr    <= '0;
            cm_ptr    <= '0;
            rd_ptr    <= '0;
            ferr      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            data_out  <= '0;
            r_last    <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            cm_ptr  <= cm_ptr_nxt;
            ferr    <= ferr_nxt;
            r_valid <= rd_fire;
            if (rd_fire) begin
                rd_ptr                <= rd_ptr + PTR_ONE;
                {r_last, data_out}    <= mem[rd_ptr[PTR_LEN-1:0]];
            end
            // Set beats clear when both happen in the same cycle.
            overflow  <= wr_ovf | (overflow  & ~clr_err);
            underflow <= rd_unf | (underflow & ~clr_err);
        end
    end

endmodule
